// File: rtl/dmac_fifo_ctl_if.sv
// Handshake and status bundle between the DMAC engines and the datapath FIFO.
// The slave modport is the FIFO side and the master modport is the engine side.
interface dmac_fifo_ctl_if #(
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  flush_i;
    logic                  wren_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  full_o;
    logic                  afull_o;
    logic                  rden_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  empty_o;
    logic                  aempty_o;
    logic [DEPTH_LG2:0]    count_o;
    logic                  ovf_o;
    logic                  udf_o;
    logic                  err_clr_i;

    modport slave (
        input  flush_i, wren_i, wdata_i, rden_i, err_clr_i,
        output full_o, afull_o, rdata_o, empty_o, aempty_o, count_o, ovf_o, udf_o
    );

    modport master (
        output flush_i, wren_i, wdata_i, rden_i, err_clr_i,
        input  full_o, afull_o, rdata_o, empty_o, aempty_o, count_o, ovf_o, udf_o
    );
endinterface

// File: rtl/dmac_fifo_ctl.sv
// Show-ahead synchronous FIFO for the DMAC datapath: registered head data,
// occupancy and almost-flags derived from next-state pointers, and sticky error flags.
module dmac_fifo_ctl #(
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int AFULL_THR  = 14,
    parameter int AEMPTY_THR = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmac_fifo_ctl_if.slave   bus
);
    localparam int              DEPTH    = 1 << DEPTH_LG2;
    localparam int              PW       = DEPTH_LG2 + 1;
    localparam logic [PW-1:0]   AFULL_C  = PW'(AFULL_THR);
    localparam logic [PW-1:0]   AEMPTY_C = PW'(AEMPTY_THR);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wrptr_q, wrptr_d;
    logic [PW-1:0]         rdptr_q, rdptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic wr_acc;
    logic rd_acc;
    logic wr_rej;
    logic rd_rej;

    always_comb begin
        wr_acc = bus.wren_i & ~full_q  & ~bus.flush_i;
        rd_acc = bus.rden_i & ~empty_q & ~bus.flush_i;
        wr_rej = bus.wren_i &  full_q  & ~bus.flush_i;
        rd_rej = bus.rden_i &  empty_q & ~bus.flush_i;
    end

    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        if (bus.flush_i) begin
            wrptr_d = '0;
            rdptr_d = '0;
        end else begin
            if (wr_acc) wrptr_d = wrptr_q + PW'(1);
            if (rd_acc) rdptr_d = rdptr_q + PW'(1);
        end
        count_d  = wrptr_d - rdptr_d;
        empty_d  = (wrptr_d == rdptr_d);
        full_d   = (wrptr_d[PW-1] != rdptr_d[PW-1]) &&
                   (wrptr_d[PW-2:0] == rdptr_d[PW-2:0]);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    // The head must bypass storage whenever the next head is the word being written this cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.flush_i) begin
            rdata_d = '0;
        end else if (wr_acc && (rdptr_d == wrptr_q)) begin
            rdata_d = bus.wdata_i;
        end else if (!empty_d) begin
            rdata_d = mem[rdptr_d[PW-2:0]];
        end
    end

    always_comb begin
        ovf_d = ovf_q | wr_rej;
        udf_d = udf_q | rd_rej;
        if (bus.err_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wrptr_q[PW-2:0]] <= bus.wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrptr_q  <= '0;
            rdptr_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wrptr_q  <= wrptr_d;
            rdptr_q  <= rdptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.full_o   = full_q;
    assign bus.afull_o  = afull_q;
    assign bus.empty_o  = empty_q;
    assign bus.aempty_o = aempty_q;
    assign bus.count_o  = count_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.udf_o    = udf_q;
    assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_dmac_fifo_ctl.sv
// Directed bench for dmac_fifo_ctl: fill, overflow, drain, streaming wrap,
// empty bypass and flush, with hand-computed expected values.
module tb_dmac_fifo_ctl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    dmac_fifo_ctl_if #(.DEPTH_LG2(4), .DATA_WIDTH(32)) bus ();

    dmac_fifo_ctl #(
        .DEPTH_LG2(4), .DATA_WIDTH(32), .AFULL_THR(14), .AEMPTY_THR(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wren_i    = 1'b0;
        bus.rden_i    = 1'b0;
        bus.flush_i   = 1'b0;
        bus.err_clr_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.wdata_i = '0;
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_full",   32'(bus.full_o),   32'd0);
        chk("rst_afull",  32'(bus.afull_o),  32'd0);
        chk("rst_empty",  32'(bus.empty_o),  32'd1);
        chk("rst_aempty", 32'(bus.aempty_o), 32'd1);
        chk("rst_count",  32'(bus.count_o),  32'd0);
        chk("rst_rdata",  bus.rdata_o,       32'd0);
        chk("rst_ovf",    32'(bus.ovf_o),    32'd0);
        chk("rst_udf",    32'(bus.udf_o),    32'd0);

        // Fill with 0x100..0x10F.
        for (int i = 0; i < 16; i++) begin
            bus.wren_i  = 1'b1;
            bus.wdata_i = 32'h100 + 32'(i);
            @(negedge clk);
            chk("fill_count",  32'(bus.count_o),  32'(i + 1));
            chk("fill_afull",  32'(bus.afull_o),  32'((i + 1) >= 14));
            chk("fill_aempty", 32'(bus.aempty_o), 32'((i + 1) <= 2));
            chk("fill_full",   32'(bus.full_o),   32'((i + 1) == 16));
            chk("fill_head",   bus.rdata_o,       32'h100);
            chk("fill_empty",  32'(bus.empty_o),  32'd0);
        end
        idle();

        // Overflow: data dropped, sticky flag set, then cleared.
        bus.wren_i  = 1'b1;
        bus.wdata_i = 32'hDEAD;
        @(negedge clk);
        idle();
        chk("ovf_set",   32'(bus.ovf_o),   32'd1);
        chk("ovf_count", 32'(bus.count_o), 32'd16);
        chk("ovf_full",  32'(bus.full_o),  32'd1);
        chk("ovf_udf",   32'(bus.udf_o),   32'd0);
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        idle();
        chk("ovf_clr", 32'(bus.ovf_o), 32'd0);

        // Drain: head sequence 0x100..0x10F, one per cycle.
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", bus.rdata_o, 32'h100 + 32'(i));
            bus.rden_i = 1'b1;
            @(negedge clk);
            chk("drain_count", 32'(bus.count_o), 32'(15 - i));
        end
        idle();
        chk("drain_empty", 32'(bus.empty_o),  32'd1);
        chk("drain_aem",   32'(bus.aempty_o), 32'd1);
        chk("drain_full",  32'(bus.full_o),   32'd0);

        bus.rden_i = 1'b1;
        @(negedge clk);
        idle();
        chk("udf_set",   32'(bus.udf_o),   32'd1);
        chk("udf_count", 32'(bus.count_o), 32'd0);
        chk("udf_ovf",   32'(bus.ovf_o),   32'd0);
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        idle();
        chk("udf_clr", 32'(bus.udf_o), 32'd0);

        // Streaming at occupancy 3 across pointer wraps.
        for (int i = 0; i < 3; i++) begin
            bus.wren_i  = 1'b1;
            bus.wdata_i = 32'h200 + 32'(i);
            @(negedge clk);
        end
        idle();
        chk("strm_pre_count", 32'(bus.count_o), 32'd3);
        for (int k = 0; k < 40; k++) begin
            chk("strm_data", bus.rdata_o, 32'h200 + 32'(k));
            bus.wren_i  = 1'b1;
            bus.rden_i  = 1'b1;
            bus.wdata_i = 32'h203 + 32'(k);
            @(negedge clk);
            chk("strm_count",  32'(bus.count_o),  32'd3);
            chk("strm_aempty", 32'(bus.aempty_o), 32'd0);
            chk("strm_afull",  32'(bus.afull_o),  32'd0);
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            chk("strm_tail", bus.rdata_o, 32'h228 + 32'(k));
            bus.rden_i = 1'b1;
            @(negedge clk);
        end
        idle();
        chk("strm_empty", 32'(bus.empty_o), 32'd1);
        chk("strm_udf",   32'(bus.udf_o),   32'd0);

        // Write into empty with a simultaneous read: read rejected, write bypasses.
        bus.wren_i  = 1'b1;
        bus.rden_i  = 1'b1;
        bus.wdata_i = 32'hA5;
        @(negedge clk);
        idle();
        chk("byp_udf",   32'(bus.udf_o),   32'd1);
        chk("byp_rdata", bus.rdata_o,      32'hA5);
        chk("byp_count", 32'(bus.count_o), 32'd1);
        chk("byp_empty", 32'(bus.empty_o), 32'd0);
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        idle();
        chk("byp_clr", 32'(bus.udf_o), 32'd0);

        // Flush at count 9 with concurrent write and read.
        for (int i = 0; i < 8; i++) begin
            bus.wren_i  = 1'b1;
            bus.wdata_i = 32'h300 + 32'(i);
            @(negedge clk);
        end
        idle();
        chk("pre_flush_count", 32'(bus.count_o), 32'd9);
        chk("pre_flush_head",  bus.rdata_o,      32'hA5);
        bus.flush_i = 1'b1;
        bus.wren_i  = 1'b1;
        bus.rden_i  = 1'b1;
        bus.wdata_i = 32'h77;
        @(negedge clk);
        idle();
        chk("flush_count", 32'(bus.count_o),  32'd0);
        chk("flush_empty", 32'(bus.empty_o),  32'd1);
        chk("flush_full",  32'(bus.full_o),   32'd0);
        chk("flush_aem",   32'(bus.aempty_o), 32'd1);
        chk("flush_rdata", bus.rdata_o,       32'd0);
        chk("flush_ovf",   32'(bus.ovf_o),    32'd0);
        chk("flush_udf",   32'(bus.udf_o),    32'd0);
        bus.wren_i  = 1'b1;
        bus.wdata_i = 32'h55;
        @(negedge clk);
        idle();
        chk("post_flush_rdata", bus.rdata_o,      32'h55);
        chk("post_flush_count", 32'(bus.count_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
